// File: rtl/varint_encoder.sv
// Protobuf base-128 varint encoder feeding a show-ahead byte FIFO.
// Each byte is tagged with the output index of its field.
module varint_encoder #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_value,
    input  logic [9:0]  in_index,
    input  logic        in_zigzag,
    output logic [7:0]  varint_out_q,
    output logic [9:0]  varint_out_index_q,
    output logic        varint_data_valid,
    input  logic        varint_enable,
    input  logic        varint_data_accepted,
    output logic        varint_err,
    output logic        state_dbg
);
    // Handshakes: a value transfers on a rising edge with in_valid && in_ready;
    // the head byte is consumed on a rising edge with varint_enable, which must
    // always be accompanied by varint_data_accepted and only when data_valid.
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        ENCODE = 1'b1
    } state_t;

    state_t        state;
    logic [63:0]   sr;
    logic [9:0]    idx;
    logic [7:0]    mem_byte [DEPTH];
    logic [9:0]    mem_idx  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          more;
    logic [7:0]    push_byte;
    logic          full;
    logic          push;
    logic          pop;

    always_comb begin
        more      = |sr[63:7];
        push_byte = {more, sr[6:0]};
        full      = (count == FULL_COUNT);
        push      = (state == ENCODE) && !full;
        pop       = varint_enable && (count != '0);
    end

    assign in_ready           = (state == IDLE);
    assign varint_data_valid  = (count != '0);
    assign varint_out_q       = mem_byte[rd_ptr];
    assign varint_out_index_q = mem_idx[rd_ptr];
    assign state_dbg          = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= '0;
            idx        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            varint_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_byte[i] <= '0;
                mem_idx[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Zigzag maps signed values so small magnitudes stay short.
                        sr    <= in_zigzag ? ({in_value[62:0], 1'b0} ^ {64{in_value[63]}})
                                           : in_value;
                        idx   <= in_index;
                        state <= ENCODE;
                    end
                end
                ENCODE: begin
                    if (push) begin
                        sr <= sr >> 7;
                        if (!more) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                mem_byte[wr_ptr] <= push_byte;
                mem_idx[wr_ptr]  <= idx;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if ((varint_enable && (count == '0)) || (varint_enable != varint_data_accepted))
                varint_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_varint_encoder.sv
// Bench for varint_encoder: vector table, random values, and hand-written
// sequences for latency, full-FIFO stall, error flag and reset mid-encode.
module tb_varint_encoder;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_value = '0;
    logic [9:0]  in_index = '0;
    logic        in_zigzag = 1'b0;
    logic [7:0]  varint_out_q;
    logic [9:0]  varint_out_index_q;
    logic        varint_data_valid;
    logic        varint_enable = 1'b0;
    logic        varint_data_accepted = 1'b0;
    logic        varint_err;
    logic        state_dbg;

    // Clock / reset
    always #5 clk = ~clk;

    varint_encoder #(.DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_value            (in_value),
        .in_index            (in_index),
        .in_zigzag           (in_zigzag),
        .varint_out_q        (varint_out_q),
        .varint_out_index_q  (varint_out_index_q),
        .varint_data_valid   (varint_data_valid),
        .varint_enable       (varint_enable),
        .varint_data_accepted(varint_data_accepted),
        .varint_err          (varint_err),
        .state_dbg           (state_dbg)
    );

    typedef struct {
        logic [63:0] value;
        logic [9:0]  index;
        logic        zz;
        int          n;
        logic [79:0] bytes;
    } vec_t;

    vec_t        vecs[11];
    logic [17:0] exp_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          pops = 0;
    bit          drain_en = 1'b0;
    logic [63:0] ones = '1;

    // Scoreboard helpers
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_model(input logic [63:0] v, input logic [9:0] ix, input logic zz);
        logic [63:0] u;
        logic [7:0]  b;
        u = zz ? ((v << 1) ^ {64{v[63]}}) : v;
        do begin
            b = {1'b0, u[6:0]};
            u = u >> 7;
            if (u != 0) b[7] = 1'b1;
            exp_q.push_back({ix, b});
        end while (u != 0);
    endfunction

    task automatic pop_now();
        logic [17:0] e;
        if (!varint_data_valid) return;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_byte: got idx %0d byte 0x%0h, expected no byte",
                     varint_out_index_q, varint_out_q);
        end else begin
            e = exp_q.pop_front();
            check("head_byte", 64'(varint_out_q), 64'(e[7:0]));
            check("head_index", 64'(varint_out_index_q), 64'(e[17:8]));
        end
        pops++;
        varint_enable = 1'b1;
        varint_data_accepted = 1'b1;
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        varint_enable = 1'b0;
        varint_data_accepted = 1'b0;
        if (drain_en) pop_now();
    endtask

    task automatic send(input logic [63:0] v, input logic [9:0] ix, input logic zz);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        check("send_ready", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_value  = v;
        in_index  = ix;
        in_zigzag = zz;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic drain_all();
        int guard;
        guard = 0;
        drain_en = 1'b1;
        if (!varint_enable) pop_now();
        while ((exp_q.size() != 0 || !in_ready) && guard < 400) begin
            tick();
            guard++;
        end
        tick();
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_valid_low", 64'(varint_data_valid), 64'd0);
        drain_en = 1'b0;
    endtask

    task automatic do_reset();
        drain_en = 1'b0;
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        vecs[0]  = '{64'd300, 10'd5, 1'b0, 2, 80'h02AC};
        vecs[1]  = '{64'd0, 10'd6, 1'b0, 1, 80'h00};
        vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 10'd1023, 1'b0, 10, 80'h01FFFFFFFFFFFFFFFFFF};
        vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 10'd1, 1'b1, 1, 80'h01};
        vecs[4]  = '{64'd1, 10'd2, 1'b1, 1, 80'h02};
        vecs[5]  = '{64'hFFFF_FFFF_FFFF_FFC0, 10'd3, 1'b1, 1, 80'h7F};
        vecs[6]  = '{64'd64, 10'd4, 1'b1, 2, 80'h0180};
        vecs[7]  = '{64'd127, 10'd8, 1'b0, 1, 80'h7F};
        vecs[8]  = '{64'd128, 10'd9, 1'b0, 2, 80'h0180};
        vecs[9]  = '{64'h8000_0000_0000_0000, 10'd10, 1'b0, 10, 80'h01808080808080808080};
        vecs[10] = '{64'h8000_0000_0000_0000, 10'd0, 1'b1, 10, 80'h01FFFFFFFFFFFFFFFFFF};

        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(varint_data_valid), 64'd0);
        check("rst_out_q", 64'(varint_out_q), 64'd0);
        check("rst_out_index", 64'(varint_out_index_q), 64'd0);
        check("rst_err", 64'(varint_err), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);

        // Latency and in_ready timing for 300
        push_model(64'd300, 10'd5, 1'b0);
        send(64'd300, 10'd5, 1'b0);
        check("lat_ready_n", 64'(in_ready), 64'd0);
        check("lat_valid_n", 64'(varint_data_valid), 64'd0);
        tick();
        check("lat_ready_n1", 64'(in_ready), 64'd0);
        check("lat_valid_n1", 64'(varint_data_valid), 64'd1);
        check("lat_head_n1", 64'(varint_out_q), 64'hAC);
        tick();
        check("lat_ready_n2", 64'(in_ready), 64'd1);
        check("lat_head_stable", 64'(varint_out_q), 64'hAC);
        drain_all();

        // Vector table
        drain_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            for (int b = 0; b < vecs[i].n; b++)
                exp_q.push_back({vecs[i].index, vecs[i].bytes[8*b +: 8]});
            send(vecs[i].value, vecs[i].index, vecs[i].zz);
        end
        drain_all();

        // Random values of varied length
        drain_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [63:0] v;
            logic [9:0]  ix;
            logic        zz;
            v  = {$urandom, $urandom} >> $urandom_range(0, 63);
            ix = 10'($urandom_range(0, 1023));
            zz = 1'($urandom_range(0, 1));
            push_model(v, ix, zz);
            send(v, ix, zz);
        end
        drain_all();
        check("err_clean", 64'(varint_err), 64'd0);

        // Full FIFO stall with two all-ones values
        do_reset();
        pops = 0;
        push_model(ones, 10'd3, 1'b0);
        push_model(ones, 10'd4, 1'b0);
        send(ones, 10'd3, 1'b0);
        send(ones, 10'd4, 1'b0);
        repeat (30) tick();
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_state", 64'(state_dbg), 64'd1);
        check("full_valid", 64'(varint_data_valid), 64'd1);
        pop_now();
        tick();
        tick();
        repeat (5) tick();
        check("full_still_stalled", 64'(state_dbg), 64'd1);
        drain_all();
        check("full_pop_count", 64'(pops), 64'd20);
        check("full_err", 64'(varint_err), 64'd0);

        // Pop while empty
        varint_enable = 1'b1;
        varint_data_accepted = 1'b1;
        tick();
        check("err_pop_empty", 64'(varint_err), 64'd1);
        check("err_pop_empty_valid", 64'(varint_data_valid), 64'd0);
        repeat (3) tick();
        check("err_sticky", 64'(varint_err), 64'd1);
        do_reset();
        check("err_cleared", 64'(varint_err), 64'd0);

        // Strobe disagreement
        push_model(64'd1, 10'd9, 1'b0);
        send(64'd1, 10'd9, 1'b0);
        tick();
        varint_enable = 1'b1;
        varint_data_accepted = 1'b0;
        tick();
        check("err_strobe", 64'(varint_err), 64'd1);
        repeat (3) tick();
        check("err_strobe_sticky", 64'(varint_err), 64'd1);
        do_reset();
        check("err_strobe_cleared", 64'(varint_err), 64'd0);

        // Reset mid-encode
        send(ones, 10'd7, 1'b0);
        do_reset();
        check("mid_rst_valid", 64'(varint_data_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        check("mid_rst_state", 64'(state_dbg), 64'd0);
        push_model(64'd300, 10'd5, 1'b0);
        send(64'd300, 10'd5, 1'b0);
        drain_all();
        check("mid_rst_err", 64'(varint_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
